uart_tx_fifo: RTL and testbench

Buffered UART transmitter with a parametrised frame format and a valid/ready write interface. Bytes are pushed into an internal FIFO of FIFO_DEPTH entries and serialised back-to-back onto out_tx. Replaces the fixed 8N1, fixed-depth transmit buffer in the UART test path. Exposes FIFO occupancy and a per-frame completion pulse for host-side flow control.

---
 rtl/uart_tx_fifo.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO in front of a framed serialiser.
// Frame format (data bits, parity, stop bits, bit time) set by parameters.
module uart_tx_fifo #(
  parameter int CYCLES_PER_BIT = 4,
  parameter int DATA_BITS      = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          out_tx,
  output logic                          out_busy,
  output logic [$clog2(FIFO_DEPTH):0]   out_count,
  output logic                          out_full,
  output logic                          out_empty,
  output logic                          out_frame_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CYCLES_PER_BIT);

  localparam logic [BW-1:0] LP_BIT_LAST  = BW'(CYCLES_PER_BIT - 1);
  localparam logic [BW-1:0] LP_DONE_AT   = BW'(CYCLES_PER_BIT - 2);
  localparam logic [3:0]    LP_DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LP_STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [CW-1:0] LP_DEPTH     = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [CW-1:0]        r_count;

  state_t               r_state;
  logic [BW-1:0]        r_cnt;
  logic [3:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_tx;
  logic                 r_done;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_bit_end;
  logic                 w_stop_end;
  logic [DATA_BITS-1:0] w_head;

  assign out_full   = (r_count == LP_DEPTH);
  assign out_empty  = (r_count == '0);
  assign in_ready   = resetn & ~out_full;
  assign out_count  = r_count;
  assign out_tx     = r_tx;
  assign out_busy   = (r_state != S_IDLE);
  assign out_frame_done = r_done;

  assign w_push     = in_valid & in_ready;
  assign w_head     = r_mem[r_rptr];
  assign w_bit_end  = (r_cnt == LP_BIT_LAST);
  assign w_stop_end = (r_state == S_STOP) && w_bit_end &&
                      (r_bit == LP_STOP_LAST);
  assign w_pop      = ~out_empty &&
                      ((r_state == S_IDLE) || w_stop_end);

  // FIFO storage; in_ready is low in reset so nothing is written then
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= in_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Frame serialiser; tx and done are registered with the state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_pop) begin
        r_state <= S_START;
        r_cnt   <= '0;
        r_bit   <= '0;
        r_shift <= w_head;
        r_par   <= (PARITY == 1) ? ~^w_head : ^w_head;
        r_tx    <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: r_tx <= 1'b1;
          S_START: begin
            if (w_bit_end) begin
              r_state <= S_DATA;
              r_cnt   <= '0;
              r_bit   <= '0;
              r_tx    <= r_shift[0];
            end else r_cnt <= r_cnt + 1'b1;
          end
          S_DATA: begin
            if (w_bit_end) begin
              r_cnt <= '0;
              if (r_bit == LP_DATA_LAST) begin
                r_bit <= '0;
                if (PARITY != 0) begin
                  r_state <= S_PARITY;
                  r_tx    <= r_par;
                end else begin
                  r_state <= S_STOP;
                  r_tx    <= 1'b1;
                end
              end else begin
                r_bit   <= r_bit + 1'b1;
                r_shift <= r_shift >> 1;
                r_tx    <= r_shift[1];
              end
            end else r_cnt <= r_cnt + 1'b1;
          end
          S_PARITY: begin
            if (w_bit_end) begin
              r_state <= S_STOP;
              r_cnt   <= '0;
              r_bit   <= '0;
              r_tx    <= 1'b1;
            end else r_cnt <= r_cnt + 1'b1;
          end
          S_STOP: begin
            if (r_cnt == LP_DONE_AT && r_bit == LP_STOP_LAST)
              r_done <= 1'b1;
            if (w_bit_end) begin
              r_cnt <= '0;
              if (r_bit == LP_STOP_LAST) begin
                r_state <= S_IDLE;
                r_tx    <= 1'b1;
              end else r_bit <= r_bit + 1'b1;
            end else r_cnt <= r_cnt + 1'b1;
          end
          default: begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four frame formats run against a
// frame-level reference model, plus directed timing checks.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rn   [4];
  logic       vld  [4];
  logic [8:0] din  [4];
  logic       rdy  [4];
  logic       tx   [4];
  logic       busy [4];
  logic       full [4];
  logic       empty[4];
  logic       done [4];
  logic [4:0] c0, c1, c3;
  logic [2:0] c2;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_on = 0;

  // model state: queue per instance, current frame word and position
  int mq [4][64];
  int mh [4], ms [4], mt [4], mw [4], nacc [4];
  bit mact [4];
  bit macc, mpop;
  int ml;

  // directed-test monitors
  int dt0 [8];
  int nd0 = 0;
  int bf0 = 0;
  bit pb0 = 0;
  int pk0 = 0;
  int d1t = 0;
  bit sawfull3 = 0;

  uart_tx_fifo u0 (
    .clk(clk), .resetn(rn[0]), .in_data(din[0][7:0]),
    .in_valid(vld[0]), .in_ready(rdy[0]), .out_tx(tx[0]),
    .out_busy(busy[0]), .out_count(c0), .out_full(full[0]),
    .out_empty(empty[0]), .out_frame_done(done[0]));

  uart_tx_fifo #(.CYCLES_PER_BIT(4), .DATA_BITS(7),
    .FIFO_DEPTH(16), .PARITY(2), .STOP_BITS(2)) u1 (
    .clk(clk), .resetn(rn[1]), .in_data(din[1][6:0]),
    .in_valid(vld[1]), .in_ready(rdy[1]), .out_tx(tx[1]),
    .out_busy(busy[1]), .out_count(c1), .out_full(full[1]),
    .out_empty(empty[1]), .out_frame_done(done[1]));

  uart_tx_fifo #(.CYCLES_PER_BIT(3), .DATA_BITS(8),
    .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(1)) u2 (
    .clk(clk), .resetn(rn[2]), .in_data(din[2][7:0]),
    .in_valid(vld[2]), .in_ready(rdy[2]), .out_tx(tx[2]),
    .out_busy(busy[2]), .out_count(c2), .out_full(full[2]),
    .out_empty(empty[2]), .out_frame_done(done[2]));

  uart_tx_fifo #(.CYCLES_PER_BIT(16), .DATA_BITS(8),
    .FIFO_DEPTH(16), .PARITY(0), .STOP_BITS(1)) u3 (
    .clk(clk), .resetn(rn[3]), .in_data(din[3][7:0]),
    .in_valid(vld[3]), .in_ready(rdy[3]), .out_tx(tx[3]),
    .out_busy(busy[3]), .out_count(c3), .out_full(full[3]),
    .out_empty(empty[3]), .out_frame_done(done[3]));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic int cpb(int k);
    return (k == 2) ? 3 : (k == 3) ? 16 : 4;
  endfunction
  function automatic int db(int k);
    return (k == 1) ? 7 : 8;
  endfunction
  function automatic int fd(int k);
    return (k == 2) ? 4 : 16;
  endfunction
  function automatic int par(int k);
    return (k == 1) ? 2 : (k == 2) ? 1 : 0;
  endfunction
  function automatic int sb(int k);
    return (k == 1) ? 2 : 1;
  endfunction
  function automatic int flen(int k);
    return (1 + db(k) + (par(k) != 0 ? 1 : 0) + sb(k)) * cpb(k);
  endfunction
  function automatic int gcnt(int k);
    case (k)
      0: return int'(c0);
      1: return int'(c1);
      2: return int'(c2);
      default: return int'(c3);
    endcase
  endfunction

  // expected line level for bit number idx of the frame carrying w
  function automatic logic fbit(int k, int w, int idx);
    int p;
    if (idx == 0) return 1'b0;
    if (idx <= db(k)) return 1'((w >> (idx - 1)) & 1);
    if (par(k) != 0 && idx == db(k) + 1) begin
      p = $countones(w) & 1;
      return (par(k) == 2) ? 1'(p) : 1'(1 - p);
    end
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 4; k++) begin
      if (!rn[k]) begin
        mh[k] = 0; ms[k] = 0; mact[k] = 0; mt[k] = 0;
      end else begin
        ml = flen(k);
        macc = vld[k] && (ms[k] != fd(k));
        mpop = (ms[k] > 0) && (!mact[k] || mt[k] == ml - 1);
        if (mpop) begin
          mw[k] = mq[k][mh[k]];
          mh[k] = (mh[k] + 1) % 64;
          ms[k]--;
          mact[k] = 1;
          mt[k] = 0;
        end else if (mact[k]) begin
          if (mt[k] == ml - 1) mact[k] = 0;
          else mt[k]++;
        end
        if (macc) begin
          mq[k][(mh[k] + ms[k]) % 64] =
            int'(din[k]) & ((1 << db(k)) - 1);
          ms[k]++;
          nacc[k]++;
        end
      end
    end
  endtask

  task automatic check_all();
    logic etx;
    for (int k = 0; k < 4; k++) begin
      etx = mact[k] ? fbit(k, mw[k], mt[k] / cpb(k)) : 1'b1;
      check($sformatf("i%0d tx", k), 32'(tx[k]), 32'(etx));
      check($sformatf("i%0d busy", k), 32'(busy[k]), 32'(mact[k]));
      check($sformatf("i%0d done", k), 32'(done[k]),
            32'(mact[k] && mt[k] == flen(k) - 1));
      check($sformatf("i%0d count", k), 32'(gcnt(k)), 32'(ms[k]));
      check($sformatf("i%0d full", k), 32'(full[k]),
            32'(ms[k] == fd(k)));
      check($sformatf("i%0d empty", k), 32'(empty[k]),
            32'(ms[k] == 0));
      check($sformatf("i%0d ready", k), 32'(rdy[k]),
            32'(rn[k] && ms[k] != fd(k)));
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) check_all();
    if (done[0] && nd0 < 8) begin
      dt0[nd0] = cyc;
      nd0++;
    end
    if (pb0 && !busy[0]) bf0 = cyc;
    pb0 = busy[0];
    if (int'(c0) > pk0) pk0 = int'(c0);
    if (done[1]) d1t = cyc;
    if (full[3] && !rdy[3] && c3 == 5'd16) sawfull3 = 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int k, input logic [8:0] d,
                      output int n);
    vld[k] = 1;
    din[k] = d;
    n = cyc;
    tick(1);
    vld[k] = 0;
  endtask

  int n, n2;

  initial begin
    for (int k = 0; k < 4; k++) begin
      rn[k] = 0; vld[k] = 0; din[k] = '0;
    end
    tick(2);
    chk_on = 1;
    tick(2);
    for (int k = 0; k < 4; k++) rn[k] = 1;
    tick(3);

    // single 0xA5 frame, default format
    nd0 = 0;
    push(0, 9'h0A5, n);
    tick(45);
    check("t1 done cycle", 32'(dt0[0] - n), 32'd41);
    check("t1 busy fall", 32'(bf0 - n), 32'd42);

    // three back-to-back frames
    nd0 = 0;
    pk0 = 0;
    push(0, 9'h001, n);
    push(0, 9'h002, n2);
    push(0, 9'h003, n2);
    tick(125);
    check("t2 peak count", 32'(pk0), 32'd2);
    check("t2 n done", 32'(nd0), 32'd3);
    check("t2 gap a", 32'(dt0[1] - dt0[0]), 32'd40);
    check("t2 gap b", 32'(dt0[2] - dt0[1]), 32'd40);

    // 7E2 frame length
    push(1, 9'h007, n);
    tick(50);
    check("t4 done cycle", 32'(d1t - n), 32'd45);

    // odd parity bit values
    push(2, 9'h003, n);
    tick(29);
    @(negedge clk);
    check("t5 par 0x03", 32'(tx[2]), 32'd1);
    tick(10);
    push(2, 9'h007, n);
    tick(29);
    @(negedge clk);
    check("t5 par 0x07", 32'(tx[2]), 32'd0);
    tick(10);

    // reset during the second queued frame
    push(0, 9'h011, n);
    push(0, 9'h022, n2);
    push(0, 9'h033, n2);
    tick(47);
    rn[0] = 0;
    tick(1);
    @(negedge clk);
    check("t6 tx", 32'(tx[0]), 32'd1);
    check("t6 count", 32'(c0), 32'd0);
    check("t6 busy", 32'(busy[0]), 32'd0);
    check("t6 ready", 32'(rdy[0]), 32'd0);
    tick(1);
    rn[0] = 1;
    @(negedge clk);
    check("t6 ready rel", 32'(rdy[0]), 32'd1);
    push(0, 9'h03C, n);
    tick(45);

    // randomized traffic; instance 3 holds valid to fill and wrap
    fork
      begin
        vld[3] = 1;
        repeat (900) begin
          din[3] = 9'($urandom);
          tick(1);
        end
        vld[3] = 0;
      end
      begin
        repeat (900) begin
          vld[2] = 1'($urandom_range(0, 1));
          din[2] = 9'($urandom);
          tick(1);
        end
        vld[2] = 0;
      end
      begin
        repeat (900) begin
          vld[1] = ($urandom_range(0, 7) == 0);
          din[1] = 9'($urandom);
          tick(1);
        end
        vld[1] = 0;
      end
      begin
        repeat (900) begin
          vld[0] = ($urandom_range(0, 15) == 0);
          din[0] = 9'($urandom);
          tick(1);
        end
        vld[0] = 0;
      end
    join
    tick(2800);
    check("t3 saw full", 32'(sawfull3), 32'd1);
    check("t3 accepted", 32'(nacc[3] >= 20), 32'd1);
    for (int k = 0; k < 4; k++)
      check($sformatf("drain i%0d", k), 32'(empty[k]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
